// File: rtl/sysid_chk_pkg.sv
// sysid_chk_pkg: shared FSM states, fail codes and word addresses for the system ID boot checker
package sysid_chk_pkg;
    typedef enum logic [2:0] {IDLE, RD_ID, WT_ID, RD_TS, WT_TS, CHECK, DONE} state_t;
    localparam logic [1:0] FAIL_NONE    = 2'd0;
    localparam logic [1:0] FAIL_ID      = 2'd1;
    localparam logic [1:0] FAIL_TS      = 2'd2;
    localparam logic [1:0] FAIL_TIMEOUT = 2'd3;
    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;
endpackage

// File: rtl/sysid_chk_timer.sv
// sysid_chk_timer: per-read timeout counter, cleared on read entry and flagging expiry at TIMEOUT_CYCLES
module sysid_chk_timer #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic expired
);
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clock) begin
        if (reset || clr) cnt <= '0;
        else if (inc) cnt <= cnt + 1'b1;
    end
    assign expired = cnt == CNT_W'(TIMEOUT_CYCLES);
endmodule

// File: rtl/sysid_boot_checker.sv
// sysid_boot_checker: reads sysid ID/timestamp over Avalon-MM and checks them; timeout path under SYSID_CHK_TIMEOUT_EN
module sysid_boot_checker
    import sysid_chk_pkg::*;
#(
    parameter logic [31:0] EXP_ID         = 32'd0,
    parameter logic [31:0] EXP_TIMESTAMP  = 32'd1543545716,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter int          CNT_W          = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [1:0]  fail_code,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);
    state_t state, next;
    logic rd, wt, expired, timeout;
    always_comb begin
        rd      = state == RD_ID || state == RD_TS;
        wt      = state == WT_ID || state == WT_TS;
        timeout = expired && (rd || (wt && !avm_readdatavalid));
        next    = state;
        case (state)
            IDLE:    next = RD_ID;
            RD_ID:   next = timeout ? DONE : !avm_waitrequest ? WT_ID : RD_ID;
            WT_ID:   next = avm_readdatavalid ? RD_TS : timeout ? DONE : WT_ID;
            RD_TS:   next = timeout ? DONE : !avm_waitrequest ? WT_TS : RD_TS;
            WT_TS:   next = avm_readdatavalid ? CHECK : timeout ? DONE : WT_TS;
            CHECK:   next = DONE;
            DONE:    next = start ? RD_ID : DONE;
            default: next = IDLE;
        endcase
    end
    assign avm_read    = rd;
    assign avm_address = state == RD_TS ? ADDR_TS : ADDR_ID;
    assign busy        = state != IDLE && state != DONE;
    assign done        = state == DONE;
`ifdef SYSID_CHK_TIMEOUT_EN
    sysid_chk_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .clr    (next != state && (next == RD_ID || next == RD_TS)),
        .inc    (rd || wt),
        .expired(expired)
    );
`else
    assign expired = TIMEOUT_CYCLES < 0 && CNT_W < 0;
`endif
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            pass      <= 1'b0;
            fail_code <= FAIL_NONE;
            id_value  <= '0;
            ts_value  <= '0;
        end else begin
            state <= next;
            if (state == WT_ID && avm_readdatavalid) id_value <= avm_readdata;
            if (state == WT_TS && avm_readdatavalid) ts_value <= avm_readdata;
            if (state == CHECK) begin
                pass      <= id_value == EXP_ID && ts_value == EXP_TIMESTAMP;
                fail_code <= id_value != EXP_ID ? FAIL_ID : ts_value != EXP_TIMESTAMP ? FAIL_TS : FAIL_NONE;
            end else if (timeout) begin
                pass      <= 1'b0;
                fail_code <= FAIL_TIMEOUT;
            end else if (state == DONE && start) begin
                pass      <= 1'b0;
                fail_code <= FAIL_NONE;
            end
        end
    end
endmodule

// File: tb/tb_sysid_boot_checker.sv
// tb_sysid_boot_checker: table + random runs against an Avalon slave model and a cycle-count reference model
module tb_sysid_boot_checker;
    localparam int T = 255;
    localparam logic [31:0] EID = 32'd0;
    localparam logic [31:0] ETS = 32'd1543545716;
`ifdef SYSID_CHK_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    logic clock = 1'b0, reset = 1'b1, start = 1'b0;
    logic avm_waitrequest = 1'b0, avm_readdatavalid = 1'b0;
    logic [31:0] avm_readdata = '0;
    logic avm_address, avm_read, busy, done, pass;
    logic [1:0] fail_code;
    logic [31:0] id_value, ts_value;
    int vectors = 0, miscompares = 0;
    logic [31:0] m_id = '0, m_ts = '0;

    sysid_boot_checker dut (
        .clock(clock), .reset(reset), .start(start),
        .avm_address(avm_address), .avm_read(avm_read), .avm_waitrequest(avm_waitrequest),
        .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
        .busy(busy), .done(done), .pass(pass), .fail_code(fail_code),
        .id_value(id_value), .ts_value(ts_value)
    );

    always #5 clock = ~clock;

    typedef struct {
        int w; int l0; int l1;
        logic [31:0] id; logic [31:0] ts;
        int e_done; bit e_pass; logic [1:0] e_fc;
    } vec_t;
    typedef struct {int done; bit pass; logic [1:0] fc; int rd_hi; bit cap_id; bit cap_ts;} exp_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // w wait cycles per read, l0/l1 cycles from acceptance to data; a read dies if its data is not back by count T
    function automatic exp_t model(input vec_t v);
        exp_t e;
        int s1;
        e.pass = 1'b0; e.cap_id = 1'b0; e.cap_ts = 1'b0; e.fc = 2'd3;
        if (TO_EN && v.w + v.l0 > T) begin
            e.done = T + 2; e.rd_hi = (v.w < T ? v.w : T) + 1;
            return e;
        end
        e.cap_id = 1'b1;
        s1 = 2 + v.w + v.l0;
        if (TO_EN && v.w + v.l1 > T) begin
            e.done = s1 + T + 1; e.rd_hi = v.w + 1 + (v.w < T ? v.w : T) + 1;
            return e;
        end
        e.cap_ts = 1'b1;
        e.done = s1 + v.w + v.l1 + 2;
        e.rd_hi = 2 * (v.w + 1);
        e.fc = v.id != EID ? 2'd1 : v.ts != ETS ? 2'd2 : 2'd0;
        e.pass = e.fc == 2'd0;
        return e;
    endfunction

    task automatic run(input vec_t v, input int abort_at, output int done_cyc, output int rd_hi, output bit ok);
        int wleft, vat, nreq;
        logic vaddr, cur_addr;
        bit in_req;
        wleft = v.w; vat = -1; nreq = 0; vaddr = 1'b0; cur_addr = 1'b0; in_req = 1'b0;
        done_cyc = -1; rd_hi = 0; ok = 1'b1;
        for (int c = 1; c <= 700; c++) begin
            @(negedge clock);
            start = 1'b0; avm_readdatavalid = 1'b0; avm_waitrequest = 1'b0; avm_readdata = $urandom;
            if (c == abort_at) begin
                reset = 1'b1;
                return;
            end
            if (done) begin
                done_cyc = c;
                return;
            end
            if (!busy) ok = 1'b0;
            if (c == 1 && (pass || fail_code != 2'd0)) ok = 1'b0;
            if (c == 3) start = 1'b1;
            if (avm_read) begin
                rd_hi++;
                if (!in_req) begin
                    in_req = 1'b1; cur_addr = avm_address;
                    if (avm_address != (nreq == 1)) ok = 1'b0;
                end else if (avm_address != cur_addr) ok = 1'b0;
                if (wleft > 0) begin
                    avm_waitrequest = 1'b1; wleft--;
                end else begin
                    in_req = 1'b0; wleft = v.w; nreq++; vaddr = avm_address;
                    vat = c + (avm_address ? v.l1 : v.l0);
                end
                if ($urandom_range(0, 3) == 0) avm_readdatavalid = 1'b1;
            end
            if (c == vat) begin
                avm_readdatavalid = 1'b1;
                avm_readdata = vaddr ? v.ts : v.id;
            end
        end
    endtask

    task automatic exec(input vec_t v, input string tag);
        exp_t e;
        int dc, rh;
        bit ok;
        e = model(v);
        run(v, 0, dc, rh, ok);
        if (e.cap_id) m_id = v.id;
        if (e.cap_ts) m_ts = v.ts;
        chk({tag, "_done_cycle"}, 64'(dc), 64'(v.e_done));
        chk({tag, "_pass"}, 64'(pass), 64'(v.e_pass));
        chk({tag, "_fail_code"}, 64'(fail_code), 64'(v.e_fc));
        chk({tag, "_read_cycles"}, 64'(rh), 64'(e.rd_hi));
        chk({tag, "_protocol"}, 64'(ok), 64'd1);
        chk({tag, "_id_value"}, 64'(id_value), 64'(m_id));
        chk({tag, "_ts_value"}, 64'(ts_value), 64'(m_ts));
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        repeat (3) @(negedge clock);
        chk({tag, "_hold"}, 64'({done, pass, fail_code}), 64'({1'b1, v.e_pass, v.e_fc}));
    endtask

    initial begin
        vec_t v;
        exp_t e;
        int dc, rh;
        bit ok;
        tbl.push_back('{0, 1, 1, EID, ETS, 6, 1'b1, 2'd0});
        tbl.push_back('{0, 1, 1, 32'h1, ETS, 6, 1'b0, 2'd1});
        tbl.push_back('{0, 1, 1, 32'h1, 32'h5, 6, 1'b0, 2'd1});
        tbl.push_back('{0, 1, 1, EID, 32'h5, 6, 1'b0, 2'd2});
        tbl.push_back('{3, 1, 1, EID, ETS, 12, 1'b1, 2'd0});
        tbl.push_back('{1, 2, 3, EID, ETS, 11, 1'b1, 2'd0});
        tbl.push_back('{2, 1, 1, 32'hdead, ETS, 10, 1'b0, 2'd1});
        if (TO_EN) begin
            tbl.push_back('{0, 1000, 1, 32'h77, ETS, 257, 1'b0, 2'd3});
            tbl.push_back('{0, 255, 1, EID, ETS, 260, 1'b1, 2'd0});
            tbl.push_back('{0, 256, 1, EID, ETS, 257, 1'b0, 2'd3});
            tbl.push_back('{0, 1, 1000, 32'h9, 32'h3, 259, 1'b0, 2'd3});
        end
        for (int i = 0; i < 10; i++) begin
            v.w = $urandom_range(0, 4); v.l0 = $urandom_range(1, 4); v.l1 = $urandom_range(1, 4);
            v.id = $urandom_range(0, 1) ? EID : $urandom;
            v.ts = $urandom_range(0, 1) ? ETS : $urandom;
            e = model(v);
            v.e_done = e.done; v.e_pass = e.pass; v.e_fc = e.fc;
            tbl.push_back(v);
        end
        repeat (3) @(negedge clock);
        chk("reset_ctl", 64'({avm_read, avm_address, busy, done, pass, fail_code}), 64'd0);
        chk("reset_data", {id_value, ts_value}, 64'd0);
        reset = 1'b0;
        for (int i = 0; i < tbl.size(); i++) begin
            if (i > 0) start = 1'b1;
            exec(tbl[i], $sformatf("row%0d", i));
        end
        start = 1'b1;
        v = '{0, 1, 1, 32'h1, ETS, 6, 1'b1, 2'd0};
        run(v, 4, dc, rh, ok);
        chk("midrun_id_captured", 64'(id_value), 64'h1);
        chk("midrun_busy", 64'(busy), 64'd1);
        @(negedge clock);
        chk("midrun_reset_ctl", 64'({avm_read, avm_address, busy, done, pass, fail_code}), 64'd0);
        chk("midrun_reset_data", {id_value, ts_value}, 64'd0);
        m_id = '0; m_ts = '0;
        reset = 1'b0;
        exec('{0, 1, 1, EID, ETS, 6, 1'b1, 2'd0}, "after_reset");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
